// File: rtl/frv_pipeline_retire_if.sv
// Stage-4 bundle, data-memory response and retire/trap/GPR/forwarding signals
// shared between the frv memory stage, the retire stage and the register file.
interface frv_pipeline_retire_if #(
   parameter int XLEN = 32,
   parameter int OP_W = 5,
   parameter int FU_W = 5
);
   logic            flush;
   logic [4:0]      s4_rd;
   logic [XLEN-1:0] s4_opr_a;
   logic [XLEN-1:0] s4_opr_b;
   logic [OP_W-1:0] s4_uop;
   logic [FU_W-1:0] s4_fu;
   logic            s4_trap;
   logic [1:0]      s4_size;
   logic [31:0]     s4_instr;
   logic            s4_valid;
   logic            s4_busy;
   logic            dmem_recv;
   logic            dmem_error;
   logic [XLEN-1:0] dmem_rdata;
   logic            gpr_wen;
   logic [4:0]      gpr_rd;
   logic [XLEN-1:0] gpr_wdata;
   logic            trap_valid;
   logic [5:0]      trap_cause;
   logic [31:0]     trap_instr;
   logic            instr_ret;
   logic [31:0]     ret_instr;
   logic [4:0]      fwd_s4_rd;
   logic [XLEN-1:0] fwd_s4_wdata;
   logic            fwd_s4_load;
   logic            rsp_overflow;
   logic            dbg_state;      // 1 while draining an orphaned response
   logic            dbg_buf_valid;

   modport master (
      output flush, s4_rd, s4_opr_a, s4_opr_b, s4_uop, s4_fu, s4_trap, s4_size,
             s4_instr, s4_valid, dmem_recv, dmem_error, dmem_rdata,
      input  s4_busy, gpr_wen, gpr_rd, gpr_wdata, trap_valid, trap_cause,
             trap_instr, instr_ret, ret_instr, fwd_s4_rd, fwd_s4_wdata,
             fwd_s4_load, rsp_overflow, dbg_state, dbg_buf_valid
   );

   modport slave (
      input  flush, s4_rd, s4_opr_a, s4_opr_b, s4_uop, s4_fu, s4_trap, s4_size,
             s4_instr, s4_valid, dmem_recv, dmem_error, dmem_rdata,
      output s4_busy, gpr_wen, gpr_rd, gpr_wdata, trap_valid, trap_cause,
             trap_instr, instr_ret, ret_instr, fwd_s4_rd, fwd_s4_wdata,
             fwd_s4_load, rsp_overflow, dbg_state, dbg_buf_valid
   );
endinterface

// File: rtl/frv_pipeline_retire.sv
// frv writeback/retire stage: pairs LSU ops with in-order memory responses,
// aligns load data, writes the GPR file, raises traps and pulses retire.
module frv_pipeline_retire #(
   parameter int XLEN = 32,
   parameter int OP_W = 5,
   parameter int FU_W = 5
) (
   input logic                  g_clk,
   input logic                  g_reset,
   frv_pipeline_retire_if.slave bus
);
   localparam int FU_LSU = 2;

   typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic            buf_valid_q, buf_valid_d;
   logic            buf_error_q, buf_error_d;
   logic [XLEN-1:0] buf_rdata_q, buf_rdata_d;
   logic            overflow_q, overflow_d;
   logic            gpr_wen_q, gpr_wen_d;
   logic [4:0]      gpr_rd_q, gpr_rd_d;
   logic [XLEN-1:0] gpr_wdata_q, gpr_wdata_d;
   logic            trap_valid_q, trap_valid_d;
   logic [5:0]      trap_cause_q, trap_cause_d;
   logic [31:0]     trap_instr_q, trap_instr_d;
   logic            instr_ret_q, instr_ret_d;
   logic [31:0]     ret_instr_q, ret_instr_d;

   logic            is_lsu, in_run, rsp_avail, lsu_wait, busy;
   logic            consume, consume_buf, consume_live, retire;
   logic            rsp_err;
   logic [XLEN-1:0] rsp_data, load_data;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic            unused_inputs;

   // Handshake: the bundle on s4_* is taken (retired or flushed) on any clock
   // edge where s4_valid is high and s4_busy is low; while s4_busy is high the
   // producer holds the bundle stable. dmem_recv has no back-pressure.
   always_comb begin
      is_lsu       = bus.s4_fu[FU_LSU];
      in_run       = (state_q == ST_RUN);
      rsp_avail    = buf_valid_q || bus.dmem_recv;
      lsu_wait     = bus.s4_valid && is_lsu && !bus.s4_trap;
      busy         = (lsu_wait && !rsp_avail) || !in_run;
      // A flushed LSU still swallows the response it was owed.
      consume      = in_run && lsu_wait && rsp_avail;
      consume_buf  = consume && buf_valid_q;
      consume_live = consume && !buf_valid_q;
      retire       = in_run && bus.s4_valid && !busy && !bus.flush;

      rsp_err  = buf_valid_q ? buf_error_q : bus.dmem_error;
      rsp_data = buf_valid_q ? buf_rdata_q : bus.dmem_rdata;
      ld_byte  = rsp_data[{bus.s4_opr_b[1:0], 3'b000} +: 8];
      ld_half  = rsp_data[{bus.s4_opr_b[1], 4'b0000} +: 16];
      case (bus.s4_uop[2:1])
         2'b01:   load_data = {{(XLEN-8){bus.s4_uop[0] & ld_byte[7]}}, ld_byte};
         2'b10:   load_data = {{(XLEN-16){bus.s4_uop[0] & ld_half[15]}}, ld_half};
         default: load_data = rsp_data;
      endcase

      gpr_wen_d    = 1'b0;
      gpr_rd_d     = 5'd0;
      gpr_wdata_d  = '0;
      trap_valid_d = 1'b0;
      trap_cause_d = 6'd0;
      trap_instr_d = 32'd0;
      instr_ret_d  = 1'b0;
      ret_instr_d  = 32'd0;
      if (retire) begin
         instr_ret_d = 1'b1;
         ret_instr_d = bus.s4_instr;
         if (bus.s4_trap) begin
            trap_valid_d = 1'b1;
            trap_cause_d = {1'b0, bus.s4_rd};
            trap_instr_d = bus.s4_instr;
         end else if (is_lsu && rsp_err) begin
            trap_valid_d = 1'b1;
            trap_cause_d = bus.s4_uop[4] ? 6'd7 : 6'd5;
            trap_instr_d = bus.s4_instr;
         end else if ((!is_lsu || bus.s4_uop[3]) && bus.s4_rd != 5'd0) begin
            gpr_wen_d   = 1'b1;
            gpr_rd_d    = bus.s4_rd;
            gpr_wdata_d = is_lsu ? load_data : bus.s4_opr_a;
         end
      end

      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_error_d = buf_error_q;
      buf_rdata_d = buf_rdata_q;
      overflow_d  = overflow_q;
      if (in_run) begin
         if (consume_buf) begin
            buf_valid_d = 1'b0;
         end
         if (bus.dmem_recv && !consume_live) begin
            if (buf_valid_q && !consume_buf) begin
               overflow_d = 1'b1;
            end else begin
               buf_valid_d = 1'b1;
               buf_error_d = bus.dmem_error;
               buf_rdata_d = bus.dmem_rdata;
            end
         end
         if (bus.flush && lsu_wait && !rsp_avail) begin
            state_d = ST_DRAIN;
         end
      end else if (bus.dmem_recv) begin
         // The orphaned response is dropped here rather than buffered.
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q      <= ST_RUN;
         buf_valid_q  <= 1'b0;
         buf_error_q  <= 1'b0;
         buf_rdata_q  <= '0;
         overflow_q   <= 1'b0;
         gpr_wen_q    <= 1'b0;
         gpr_rd_q     <= 5'd0;
         gpr_wdata_q  <= '0;
         trap_valid_q <= 1'b0;
         trap_cause_q <= 6'd0;
         trap_instr_q <= 32'd0;
         instr_ret_q  <= 1'b0;
         ret_instr_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         buf_valid_q  <= buf_valid_d;
         buf_error_q  <= buf_error_d;
         buf_rdata_q  <= buf_rdata_d;
         overflow_q   <= overflow_d;
         gpr_wen_q    <= gpr_wen_d;
         gpr_rd_q     <= gpr_rd_d;
         gpr_wdata_q  <= gpr_wdata_d;
         trap_valid_q <= trap_valid_d;
         trap_cause_q <= trap_cause_d;
         trap_instr_q <= trap_instr_d;
         instr_ret_q  <= instr_ret_d;
         ret_instr_q  <= ret_instr_d;
      end
   end

   assign bus.s4_busy       = busy;
   assign bus.gpr_wen       = gpr_wen_q;
   assign bus.gpr_rd        = gpr_rd_q;
   assign bus.gpr_wdata     = gpr_wdata_q;
   assign bus.trap_valid    = trap_valid_q;
   assign bus.trap_cause    = trap_cause_q;
   assign bus.trap_instr    = trap_instr_q;
   assign bus.instr_ret     = instr_ret_q;
   assign bus.ret_instr     = ret_instr_q;
   assign bus.fwd_s4_rd     = bus.s4_valid ? bus.s4_rd : 5'd0;
   assign bus.fwd_s4_wdata  = bus.s4_opr_a;
   assign bus.fwd_s4_load   = lsu_wait && bus.s4_uop[3] && busy;
   assign bus.rsp_overflow  = overflow_q;
   assign bus.dbg_state     = state_q;
   assign bus.dbg_buf_valid = buf_valid_q;

   assign unused_inputs = ^{bus.s4_size, bus.s4_opr_b, bus.s4_fu};
endmodule

// File: tb/tb_frv_pipeline_retire.sv
// Bench for frv_pipeline_retire: vector table of single-cycle retires plus
// hand-written LSU, buffering, error, flush/drain and overflow sequences.
module tb_frv_pipeline_retire;
   localparam int XLEN = 32;
   localparam int EW   = 1 + 1 + 5 + XLEN + 1 + 6 + 32 + 32;
   localparam logic [4:0] FU_ALU = 5'b00001;
   localparam logic [4:0] FU_MUL = 5'b00010;
   localparam logic [4:0] FU_LSU = 5'b00100;
   localparam logic [4:0] FU_CFU = 5'b01000;
   localparam logic [4:0] FU_CSR = 5'b10000;
   localparam logic [4:0] UOP_LB  = 5'b01011;
   localparam logic [4:0] UOP_LHU = 5'b01100;
   localparam logic [4:0] UOP_LW  = 5'b01110;
   localparam logic [4:0] UOP_SW  = 5'b10110;

   logic g_clk = 1'b0;
   logic g_reset = 1'b1;
   always #5 g_clk = ~g_clk;

   frv_pipeline_retire_if #(.XLEN(XLEN), .OP_W(5), .FU_W(5)) bus ();

   frv_pipeline_retire #(.XLEN(XLEN), .OP_W(5), .FU_W(5)) dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .bus     (bus)
   );

   typedef struct {
      logic [4:0]      fu;
      logic [4:0]      uop;
      logic [4:0]      rd;
      logic [XLEN-1:0] opr_a;
      logic            trap;
      logic            exp_wen;
      logic [XLEN-1:0] exp_wdata;
      logic            exp_trap;
      logic [5:0]      exp_cause;
   } vec_t;

   vec_t           vecs[7];
   logic [EW-1:0]  exp_q[$];
   int             n_cmp = 0;
   int             n_fail = 0;
   logic           mon_en = 1'b0;
   logic [XLEN-1:0] rnd;

   function automatic logic [EW-1:0] mk_exp(input logic wen, input logic [4:0] rd,
                                            input logic [XLEN-1:0] wd, input logic tv,
                                            input logic [5:0] cause, input logic [31:0] instr);
      return {1'b1, wen, wen ? rd : 5'd0, wen ? wd : {XLEN{1'b0}},
              tv, tv ? cause : 6'd0, tv ? instr : 32'd0, instr};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic clear_rsp();
      bus.dmem_recv  = 1'b0;
      bus.dmem_error = 1'b0;
      bus.dmem_rdata = '0;
   endtask

   task automatic drive_rsp(input logic err, input logic [XLEN-1:0] data);
      bus.dmem_recv  = 1'b1;
      bus.dmem_error = err;
      bus.dmem_rdata = data;
   endtask

   task automatic idle();
      bus.flush    = 1'b0;
      bus.s4_valid = 1'b0;
      bus.s4_rd    = 5'd0;
      bus.s4_opr_a = '0;
      bus.s4_opr_b = '0;
      bus.s4_uop   = 5'd0;
      bus.s4_fu    = 5'd0;
      bus.s4_trap  = 1'b0;
      bus.s4_size  = 2'b10;
      bus.s4_instr = 32'd0;
      clear_rsp();
   endtask

   task automatic drive_op(input logic [4:0] fu, input logic [4:0] uop, input logic [4:0] rd,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic trap, input logic [31:0] instr);
      bus.s4_valid = 1'b1;
      bus.s4_fu    = fu;
      bus.s4_uop   = uop;
      bus.s4_rd    = rd;
      bus.s4_opr_a = a;
      bus.s4_opr_b = b;
      bus.s4_trap  = trap;
      bus.s4_instr = instr;
   endtask

   // Scoreboard: every retire pulse must match the oldest expectation.
   always @(negedge g_clk) begin
      logic [EW-1:0] act, e;
      if (mon_en && (bus.instr_ret || bus.gpr_wen || bus.trap_valid)) begin
         act = {bus.instr_ret, bus.gpr_wen, bus.gpr_rd, bus.gpr_wdata, bus.trap_valid,
                bus.trap_cause, bus.trap_instr, bus.ret_instr};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h expected no retire", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL sb_retire: got %h expected %h", act, e);
            end
         end
      end
   end

   initial begin
      rnd = $urandom();
      vecs[0] = '{FU_ALU, 5'd0, 5'd5,  32'h0000_1234, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 6'd0};
      vecs[1] = '{FU_MUL, 5'd0, 5'd31, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0};
      vecs[2] = '{FU_ALU, 5'd0, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0, 32'h0,         1'b0, 6'd0};
      vecs[3] = '{FU_CSR, 5'd0, 5'd10, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 6'd0};
      vecs[4] = '{FU_ALU, 5'd0, 5'd2,  32'h0000_0099, 1'b1, 1'b0, 32'h0,         1'b1, 6'd2};
      vecs[5] = '{FU_LSU, UOP_LW, 5'd13, 32'h0000_000F, 1'b1, 1'b0, 32'h0,       1'b1, 6'd13};
      vecs[6] = '{FU_CFU, 5'd0, 5'd7,  rnd,           1'b0, 1'b1, rnd,           1'b0, 6'd0};

      idle();
      g_reset = 1'b1;
      repeat (3) tick();
      g_reset = 1'b0;
      #1;
      check("rst_gpr_wen", bus.gpr_wen, 0);
      check("rst_gpr_wdata", bus.gpr_wdata, 0);
      check("rst_trap_valid", bus.trap_valid, 0);
      check("rst_instr_ret", bus.instr_ret, 0);
      check("rst_overflow", bus.rsp_overflow, 0);
      check("rst_busy", bus.s4_busy, 0);
      check("rst_buf_valid", bus.dbg_buf_valid, 0);
      check("rst_state", bus.dbg_state, 0);
      mon_en = 1'b1;

      // Back-to-back single-cycle retires from the vector table.
      for (int i = 0; i < 7; i++) begin
         drive_op(vecs[i].fu, vecs[i].uop, vecs[i].rd, vecs[i].opr_a, 32'h0,
                  vecs[i].trap, 32'h1000_0000 + i);
         #1;
         check("vec_busy", bus.s4_busy, 0);
         check("vec_fwd_rd", bus.fwd_s4_rd, vecs[i].rd);
         exp_q.push_back(mk_exp(vecs[i].exp_wen, vecs[i].rd, vecs[i].exp_wdata,
                                vecs[i].exp_trap, vecs[i].exp_cause, 32'h1000_0000 + i));
         tick();
         check("vec_instr_ret", bus.instr_ret, 1);
         check("vec_gpr_wen", bus.gpr_wen, vecs[i].exp_wen);
      end
      idle();
      tick();

      // LB signed at byte 3, response two cycles late.
      drive_op(FU_LSU, UOP_LB, 5'd9, 32'h8, 32'h103, 1'b0, 32'h0030_0483);
      #1;
      check("lb_busy_c1", bus.s4_busy, 1);
      check("lb_fwd_load", bus.fwd_s4_load, 1);
      tick();
      check("lb_busy_c2", bus.s4_busy, 1);
      tick();
      drive_rsp(1'b0, 32'h80FF_0000);
      #1;
      check("lb_busy_rsp", bus.s4_busy, 0);
      exp_q.push_back(mk_exp(1'b1, 5'd9, 32'hFFFF_FF80, 1'b0, 6'd0, 32'h0030_0483));
      tick();
      idle();
      check("lb_wdata", bus.gpr_wdata, 32'hFFFF_FF80);
      tick();

      // LHU at halfword 1.
      drive_op(FU_LSU, UOP_LHU, 5'd10, 32'hC, 32'h102, 1'b0, 32'h0021_5503);
      tick();
      tick();
      drive_rsp(1'b0, 32'h80FF_0000);
      exp_q.push_back(mk_exp(1'b1, 5'd10, 32'h0000_80FF, 1'b0, 6'd0, 32'h0021_5503));
      tick();
      idle();
      check("lhu_wdata", bus.gpr_wdata, 32'h0000_80FF);
      tick();

      // Response arrives before its load; served from the buffer.
      rnd = $urandom_range(32'h7FFF_FFFF, 1);
      drive_rsp(1'b0, rnd);
      tick();
      clear_rsp();
      check("buf_captured", bus.dbg_buf_valid, 1);
      drive_op(FU_LSU, UOP_LW, 5'd12, 32'hF, 32'h200, 1'b0, 32'h2000_0603);
      #1;
      check("buf_busy", bus.s4_busy, 0);
      exp_q.push_back(mk_exp(1'b1, 5'd12, rnd, 1'b0, 6'd0, 32'h2000_0603));
      tick();
      idle();
      check("buf_emptied", bus.dbg_buf_valid, 0);
      check("buf_wdata", bus.gpr_wdata, rnd);

      // Store with bus error, then load with late bus error, then clean store.
      drive_op(FU_LSU, UOP_SW, 5'd0, 32'hF, 32'h40, 1'b0, 32'h0020_2023);
      drive_rsp(1'b1, 32'h0);
      exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b1, 6'd7, 32'h0020_2023));
      tick();
      idle();
      check("st_err_cause", bus.trap_cause, 7);
      check("st_err_wen", bus.gpr_wen, 0);
      drive_op(FU_LSU, UOP_LW, 5'd3, 32'hF, 32'h44, 1'b0, 32'h0440_2183);
      tick();
      drive_rsp(1'b1, 32'h0000_FFFF);
      exp_q.push_back(mk_exp(1'b0, 5'd3, 32'h0, 1'b1, 6'd5, 32'h0440_2183));
      tick();
      idle();
      check("ld_err_cause", bus.trap_cause, 5);
      check("ld_err_wen", bus.gpr_wen, 0);
      drive_op(FU_LSU, UOP_SW, 5'd0, 32'hF, 32'h48, 1'b0, 32'h0020_2423);
      drive_rsp(1'b0, 32'h0);
      exp_q.push_back(mk_exp(1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 32'h0020_2423));
      tick();
      idle();

      // Flushes of an ALU op and of an LSU with its response present.
      drive_op(FU_ALU, 5'd0, 5'd8, 32'h88, 32'h0, 1'b0, 32'h0880_0413);
      bus.flush = 1'b1;
      tick();
      idle();
      check("flush_alu_ret", bus.instr_ret, 0);
      drive_op(FU_LSU, UOP_LW, 5'd11, 32'hF, 32'h80, 1'b0, 32'h0800_2583);
      drive_rsp(1'b0, 32'h1111_1111);
      bus.flush = 1'b1;
      tick();
      idle();
      check("flush_lsu_ret", bus.instr_ret, 0);
      check("flush_lsu_buf", bus.dbg_buf_valid, 0);
      check("flush_lsu_state", bus.dbg_state, 0);

      // Flush while a load waits: drain its response, then an ALU op retires.
      drive_op(FU_LSU, UOP_LW, 5'd4, 32'hF, 32'h300, 1'b0, 32'h3000_2203);
      tick();
      check("drain_wait_busy", bus.s4_busy, 1);
      bus.flush = 1'b1;
      tick();
      idle();
      check("drain_state", bus.dbg_state, 1);
      check("drain_busy_idle", bus.s4_busy, 1);
      drive_op(FU_ALU, 5'd0, 5'd6, 32'h77, 32'h0, 1'b0, 32'h0770_0313);
      tick();
      check("drain_busy_alu", bus.s4_busy, 1);
      drive_rsp(1'b0, 32'hBAD0_BAD0);
      #1;
      check("drain_busy_rsp", bus.s4_busy, 1);
      tick();
      clear_rsp();
      #1;
      check("drain_exit_state", bus.dbg_state, 0);
      check("drain_exit_buf", bus.dbg_buf_valid, 0);
      check("drain_exit_busy", bus.s4_busy, 0);
      check("drain_no_write", bus.gpr_wen, 0);
      exp_q.push_back(mk_exp(1'b1, 5'd6, 32'h77, 1'b0, 6'd0, 32'h0770_0313));
      tick();
      idle();
      check("drain_alu_wdata", bus.gpr_wdata, 32'h77);

      // Reset in the middle of a drain.
      drive_op(FU_LSU, UOP_LW, 5'd14, 32'hF, 32'h400, 1'b0, 32'h4000_2703);
      bus.flush = 1'b1;
      tick();
      idle();
      check("rst_mid_drain", bus.dbg_state, 1);
      g_reset = 1'b1;
      tick();
      g_reset = 1'b0;
      check("rst_mid_state", bus.dbg_state, 0);
      check("rst_mid_busy", bus.s4_busy, 0);

      // Two unclaimed responses overflow the buffer; sticky until reset.
      drive_rsp(1'b0, 32'h1);
      tick();
      drive_rsp(1'b0, 32'h2);
      tick();
      clear_rsp();
      check("ovf_set", bus.rsp_overflow, 1);
      drive_op(FU_ALU, 5'd0, 5'd1, 32'h5A, 32'h0, 1'b0, 32'h05A0_0093);
      exp_q.push_back(mk_exp(1'b1, 5'd1, 32'h5A, 1'b0, 6'd0, 32'h05A0_0093));
      tick();
      idle();
      tick();
      check("ovf_sticky", bus.rsp_overflow, 1);
      g_reset = 1'b1;
      tick();
      g_reset = 1'b0;
      check("ovf_cleared", bus.rsp_overflow, 0);
      check("ovf_buf_cleared", bus.dbg_buf_valid, 0);

      tick();
      tick();
      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
